// File: rtl/my_cic_interp_pkg.sv
// rtl/my_cic_interp_pkg.sv - shared CIC types: FSM state encoding and internal width helper
//
// Purpose : definitions shared by the CIC interpolator (and its decimating sibling).
// Contents: state_t   - burst FSM state (IDLE accepts an input, RUN emits RATE outputs)
//           cic_width - internal accumulator width, DATA_WIDTH + SCALE_WIDTH + 1

package my_cic_interp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Enough headroom for the full CIC gain; any overflow beyond it wraps
  // modulo 2^WIDTH and cancels between the comb and integrator sections.
  function automatic int cic_width(input int data_width, input int scale_width);
    return data_width + scale_width + 1;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one CIC comb section, y = x - x(previous enabled sample)
//
// Ports: clk     - clock
//        reset_n - asynchronous active-low reset, clears the delay element
//        en      - advance: capture x into the delay element
//        x       - stage input (WIDTH, signed)
//        y       - stage output x - d (WIDTH, signed, combinational)

module cic_comb_stage #(
  parameter int WIDTH = 34
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] d;

  // Difference against the previous accepted sample; wraps modulo 2^WIDTH.
  assign y = x - d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d <= '0;
    end else if (en) begin
      d <= x;
    end
  end

endmodule

// File: rtl/my_cic_interp.sv
// rtl/my_cic_interp.sv - CIC interpolator: N combs at input rate, zero-stuff by RATE, N integrators
//
// Ports: clk       - clock, rising edge
//        reset_n   - asynchronous active-low reset
//        in_error  - upstream error flags (ignored)
//        in_valid  - input sample valid
//        in_ready  - input accepted this cycle (high only in IDLE)
//        in_data   - signed input sample (DATA_WIDTH)
//        out_data  - signed interpolated sample (DATA_WIDTH, registered)
//        out_error - always 2'b00
//        out_valid - out_data valid (registered)
//        out_ready - downstream accepts out_data

module my_cic_interp
  import my_cic_interp_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int RATE        = 24,
  parameter int RATE_WIDTH  = 5,
  parameter int SCALE_WIDTH = 14,
  parameter int DATA_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            in_error,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_error,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int WIDTH = cic_width(DATA_WIDTH, SCALE_WIDTH);
  localparam logic [RATE_WIDTH-1:0] LAST_PHASE = RATE_WIDTH'(RATE - 1);

  state_t                  state;
  logic [RATE_WIDTH-1:0]   phase;
  logic signed [WIDTH-1:0] comb_out;
  logic signed [WIDTH-1:0] in_ext;
  logic signed [WIDTH-1:0] stuffed;
  logic signed [WIDTH-1:0] integ_last;
  logic                    in_fire;
  logic                    advance;
  logic                    run_step;
  logic                    unused_in_error;

  assign unused_in_error = ^in_error;
  assign out_error       = 2'b00;

  assign in_ready = (state == IDLE);
  assign in_fire  = in_valid & in_ready;
  // Output register is empty or is being drained this cycle.
  assign advance  = ~out_valid | out_ready;
  assign run_step = (state == RUN) & advance;

  assign in_ext = {{(WIDTH - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  // Comb section: one update per accepted input sample.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_comb
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_out;

    if (k == 0) begin : g_first
      assign x_in = in_ext;
    end else begin : g_next
      assign x_in = g_comb[k-1].y_out;
    end

    cic_comb_stage #(
      .WIDTH(WIDTH)
    ) u_comb (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (in_fire),
      .x      (x_in),
      .y      (y_out)
    );
  end

  // Zero-stuffing: the comb result enters the integrators once per burst.
  assign stuffed = (phase == '0) ? comb_out : '0;

  // Integrator section. Each stage adds the *new* value of the previous
  // stage, so the whole chain settles within one cycle with no pipeline lag.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_integ
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] acc_in;
    logic signed [WIDTH-1:0] acc_next;

    if (k == 0) begin : g_first
      assign acc_in = stuffed;
    end else begin : g_next
      assign acc_in = g_integ[k-1].acc_next;
    end

    assign acc_next = acc + acc_in;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc <= '0;
      end else if (run_step) begin
        acc <= acc_next;
      end
    end
  end

  assign integ_last = g_integ[NUM_STAGES-1].acc_next;

  // Burst FSM: IDLE takes one input, RUN emits RATE outputs at output rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= '0;
      comb_out  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (in_fire) begin
            comb_out <= g_comb[NUM_STAGES-1].y_out;
            phase    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            out_data  <= DATA_WIDTH'(integ_last >>> SCALE_WIDTH);
            out_valid <= 1'b1;
            if (phase == LAST_PHASE) begin
              phase <= '0;
              state <= IDLE;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
